// File: rtl/posit16_pkg.sv
// Shared constants and payload types for the unpacked-to-Posit16 (es=0) packer.
package posit16_pkg;

  localparam int unsigned UNPACKED_W = 19;
  localparam int unsigned EXP_W      = 5;
  localparam int unsigned FRAC_W     = 13;
  localparam int unsigned EXP_BIAS   = 14;
  localparam int unsigned POSIT_W    = 16;
  localparam int unsigned BODY_W     = POSIT_W - 1;
  localparam int unsigned MAX_SCALE  = BODY_W - 1;

  localparam logic [POSIT_W-1:0] NAR    = 16'h8000;
  localparam logic [POSIT_W-1:0] MAXPOS = 16'h7FFF;
  localparam logic [POSIT_W-1:0] MINPOS = 16'h0001;
  localparam logic [POSIT_W-1:0] ZERO   = 16'h0000;

  // Exponents at or above this saturate to maxpos without rounding.
  localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(EXP_BIAS + MAX_SCALE + 1);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } unpacked_t;

  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,
    KIND_ZERO = 2'd1,
    KIND_NAR  = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e             kind;
    logic              sign;
    logic [BODY_W-1:0] body;
    logic              guard;
    logic              sticky;
  } stage1_t;

  function automatic logic [POSIT_W-1:0] apply_sign(input logic sign,
                                                    input logic [POSIT_W-1:0] mag);
    return sign ? (~mag + POSIT_W'(1)) : mag;
  endfunction

endpackage

// File: rtl/posit16_regime_shift.sv
// Combinational regime builder: places the regime run ahead of the fraction and
// returns the 15-bit posit body plus guard and sticky over the shifted-out bits.
module posit16_regime_shift
  import posit16_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [BODY_W-1:0] body_o_c,
  output logic              guard_o_c,
  output logic              sticky_o_c
);

  localparam int unsigned SHIFT_W   = 32;
  localparam int unsigned PAD_W     = SHIFT_W - 2 - FRAC_W;
  localparam int unsigned GUARD_POS = SHIFT_W - BODY_W - 1;

  logic [EXP_W-1:0]   shamt;
  logic [SHIFT_W-1:0] base;
  logic [SHIFT_W-1:0] shifted;

  // Arithmetic right shift replicates the leading regime bit: "10" grows into
  // e+1 ones then a zero, "01" grows into -e zeros then a one.
  always_comb begin
    shamt   = '0;
    base    = '0;
    shifted = '0;
    if (exp_i >= EXP_W'(EXP_BIAS)) begin
      if (exp_i >= EXP_W'(EXP_BIAS + MAX_SCALE)) begin
        shamt = EXP_W'(MAX_SCALE);
      end else begin
        shamt = exp_i - EXP_W'(EXP_BIAS);
      end
      base = {2'b10, frac_i, {PAD_W{1'b0}}};
    end else begin
      shamt = EXP_W'(EXP_BIAS - 1) - exp_i;
      base  = {2'b01, frac_i, {PAD_W{1'b0}}};
    end
    shifted = $unsigned($signed(base) >>> shamt);
  end

  assign body_o_c   = shifted[SHIFT_W-1 -: BODY_W];
  assign guard_o_c  = shifted[GUARD_POS];
  assign sticky_o_c = |shifted[GUARD_POS-1:0];

endmodule

// File: rtl/posit16_pack.sv
// Two-stage pipeline packing an unpacked float into Posit16 (es=0).
// Define POSIT_PACK_ROUND_EN for round-to-nearest-even; otherwise results truncate.
module posit16_pack
  import posit16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [UNPACKED_W-1:0] in_data,
  input  logic                  in_zero,
  input  logic                  in_nar,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [POSIT_W-1:0]    out_posit,
  output logic                  out_valid,
  input  logic                  out_ready
);

  unpacked_t         in_u;
  logic [BODY_W-1:0] sh_body;
  logic              sh_guard;
  logic              sh_sticky;

  logic              ready_en_q;
  logic              s1_valid_q, s1_valid_d;
  stage1_t           s1_q, s1_d;
  logic              out_valid_q, out_valid_d;
  logic [POSIT_W-1:0] out_posit_q, out_posit_d;

  logic              s2_free;
  logic              s1_advance;
  logic              in_fire;
  logic              round_up;
  logic [POSIT_W-1:0] mag_sum;
  logic [POSIT_W-1:0] mag;

  assign in_u = in_data;

  posit16_regime_shift u_regime_shift (
    .exp_i      (in_u.exp),
    .frac_i     (in_u.frac),
    .body_o_c   (sh_body),
    .guard_o_c  (sh_guard),
    .sticky_o_c (sh_sticky)
  );

  // Handshake: a stage moves when empty or when its successor drains this cycle.
  assign s2_free    = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_free;
  assign in_ready   = ready_en_q && (!s1_valid_q || s1_advance);
  assign in_fire    = in_valid && in_ready;

  // Stage 1: classify and build regime/fraction; saturated exponents bypass rounding.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_d.sign   = in_u.sign;
      s1_d.body   = sh_body;
      s1_d.guard  = sh_guard;
      s1_d.sticky = sh_sticky;
      if (in_nar) begin
        s1_d.kind = KIND_NAR;
      end else if (in_zero) begin
        s1_d.kind = KIND_ZERO;
      end else begin
        s1_d.kind = KIND_NUM;
      end
      if (in_u.exp >= EXP_SAT) begin
        s1_d.body   = BODY_W'(MAXPOS);
        s1_d.guard  = 1'b0;
        s1_d.sticky = 1'b0;
      end else if (in_u.exp == '0) begin
        s1_d.body   = BODY_W'(MINPOS);
        s1_d.guard  = 1'b0;
        s1_d.sticky = 1'b0;
      end
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

`ifdef POSIT_PACK_ROUND_EN
  assign round_up = s1_q.guard && (s1_q.sticky || s1_q.body[0]);
`else
  logic rnd_unused;
  assign round_up   = 1'b0;
  assign rnd_unused = s1_q.guard ^ s1_q.sticky;
`endif

  // Stage 2: round, clamp into minpos..maxpos, then apply sign or special encodings.
  always_comb begin
    out_valid_d = out_valid_q;
    out_posit_d = out_posit_q;
    mag_sum     = {1'b0, s1_q.body} + POSIT_W'(round_up);
    mag         = mag_sum;
    if (mag_sum > MAXPOS) begin
      mag = MAXPOS;
    end else if (mag_sum == '0) begin
      mag = MINPOS;
    end
    if (s1_advance) begin
      out_valid_d = 1'b1;
      case (s1_q.kind)
        KIND_NAR:  out_posit_d = NAR;
        KIND_ZERO: out_posit_d = ZERO;
        default:   out_posit_d = apply_sign(s1_q.sign, mag);
      endcase
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_posit_q <= out_posit_d;
    end
  end

  assign out_posit = out_posit_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_posit16_pack.sv
// Directed self-checking bench for posit16_pack; expectations follow POSIT_PACK_ROUND_EN.
module tb_posit16_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] in_data;
  logic        in_zero;
  logic        in_nar;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_posit;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-encoded vectors shared by the table-driven scenarios.
  logic [18:0] vec_d [8] = '{19'h5D2E0, 19'h600A0, 19'h1AB20, 19'h12345,
                             19'h12345, 19'h3E000, 19'h41FFF, 19'h1E000};
  logic        vec_z [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        vec_n [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] vec_e [8] = '{16'hAD20, 16'h8FD8, 16'h2B20, 16'h0000,
                             16'h8000, 16'h7FFF, 16'hFFFF, 16'h6000};

  always #5 clk = ~clk;

  posit16_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_posit (out_posit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Send one item into an idle pipeline and report its result and latency (-1 if none).
  task automatic xfer(input logic [18:0] d, input logic z, input logic n,
                      output logic [15:0] res, output int lat);
    res = 16'hxxxx;
    lat = -1;
    @(negedge clk);
    in_data = d; in_zero = z; in_nar = n; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        res = out_posit;
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_posit !== 16'h0000) begin n_fail++; $display("FAIL reset_out_posit: got %h want 0000", out_posit); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [15:0] res;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      xfer(vec_d[i], vec_z[i], vec_n[i], res, lat);
      n_tests++;
      if (res !== vec_e[i]) begin n_fail++; $display("FAIL vector_%0d: got %h want %h", i, res, vec_e[i]); end
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL vector_%0d_latency: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_boundaries();
    logic [18:0] d [4] = '{19'h12345, 19'h7E000, 19'h00000, 19'h1C000};
    logic        n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] e [4] = '{16'h8000, 16'h8001, 16'h0001, 16'h4000};
    logic [15:0] res;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      xfer(d[i], 1'b0, n[i], res, lat);
      n_tests++;
      if (res !== e[i] || lat !== 2)
        begin n_fail++; $display("FAIL boundary_%0d: got %h lat %0d want %h lat 2", i, res, lat, e[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [18:0] d [7] = '{19'h35800, 19'h34800, 19'h34801, 19'h37800,
                           19'h39000, 19'h75800, 19'h03FFF};
`ifdef POSIT_PACK_ROUND_EN
    logic [15:0] e [7] = '{16'h7FFE, 16'h7FFC, 16'h7FFD, 16'h7FFF,
                           16'h7FFF, 16'h8002, 16'h0004};
`else
    logic [15:0] e [7] = '{16'h7FFD, 16'h7FFC, 16'h7FFC, 16'h7FFE,
                           16'h7FFF, 16'h8003, 16'h0003};
`endif
    logic [15:0] res;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      xfer(d[i], 1'b0, 1'b0, res, lat);
      n_tests++;
      if (res !== e[i] || lat !== 2)
        begin n_fail++; $display("FAIL round_%0d: got %h lat %0d want %h lat 2", i, res, lat, e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [3];
    int          at  [3];
    int          nout = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (cyc < 3) begin
        in_valid = 1'b1; in_data = vec_d[cyc]; in_zero = 1'b0; in_nar = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 3) begin
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_%0d: got %b want 1", cyc, in_ready); end
      end
      if (out_valid) begin
        if (nout < 3) begin got[nout] = out_posit; at[nout] = cyc; end
        nout++;
      end
    end
    n_tests++;
    if (nout !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", nout); end
    for (int k = 0; k < 3 && k < nout; k++) begin
      n_tests++;
      if (got[k] !== vec_e[k] || at[k] !== k + 2)
        begin n_fail++; $display("FAIL b2b_item_%0d: got %h at %0d want %h at %0d", k, got[k], at[k], vec_e[k], k + 2); end
    end
  endtask

  task automatic test_stall_random();
    int          sent = 0;
    int          recv = 0;
    int          idx;
    logic        stalled = 1'b0;
    logic [15:0] prev = '0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      @(negedge clk);
      idx       = sent % 8;
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = vec_d[idx]; in_zero = vec_z[idx]; in_nar = vec_n[idx];
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_posit !== prev)
          begin n_fail++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, out_posit, prev); end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_posit !== vec_e[recv % 8])
          begin n_fail++; $display("FAIL stall_order_%0d: got %h want %h", recv, out_posit, vec_e[recv % 8]); end
        recv++;
      end
      stalled = out_valid && !out_ready;
      prev    = out_posit;
      if (in_valid && in_ready) sent++;
    end
    n_tests++;
    if (recv !== 1000) begin n_fail++; $display("FAIL stall_count: got %0d want 1000", recv); end
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic        accepted = 1'b0;
    int          nout = 0;
    logic [15:0] first = '0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_zero = 1'b0; in_nar = 1'b0; in_data = 19'h1C000;
    @(negedge clk);
    in_data = 19'h1E000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL full_before_reset: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_posit !== 16'h0000 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL midreset_clear: got v=%b %h rdy=%b want v=0 0000 rdy=0", out_valid, out_posit, in_ready); end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 19'h1AB20;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (accepted) in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (nout == 0) first = out_posit;
        nout++;
      end
      if (in_valid && in_ready) accepted = 1'b1;
    end
    n_tests++;
    if (nout !== 1 || first !== 16'h2B20)
      begin n_fail++; $display("FAIL post_reset_output: got %0d items first %h want 1 item 2b20", nout, first); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_boundaries();
    test_rounding();
    test_back_to_back();
    test_stall_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
